vga_frame_scanner: RTL and testbench

- Display-side consumer of the CPU's pixel read port: drives the framebuffer address input (`x`) of the CPU and turns the returned `pixel` word into 640x480@60 VGA signals.
- Runs on the single system clock and derives a pixel tick at clk/2 internally, so no separate vga_clk is needed.
- Shows the stored IMG_W x IMG_H image unscaled at the top-left of the screen; the rest of the active area is black.

---
 rtl/vga_frame_scanner_pkg.sv | 33 +++
 rtl/vga_frame_scanner_timing.sv | 73 +++++++
 rtl/vga_frame_scanner.sv | 106 ++++++++++
 tb/tb_vga_frame_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_scanner_pkg.sv
// Shared VGA timing constants, the per-pixel sideband record carried down the
// scan pipeline, and the counter width helper.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int IMG_W    = 256;
    localparam int IMG_H    = 256;
    localparam int ADDR_W   = 32;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic in_img;
    } vga_sig_t;

    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction
endpackage

// File: rtl/vga_frame_scanner_timing.sv
// Pixel tick (clk/2), h/v raster counters and same-cycle sync/active/image decode.
// Latency 0 from counters to decode; enable low freezes tick and counters.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int IMG_W    = vga_pkg::IMG_W,
    parameter int IMG_H    = vga_pkg::IMG_H,
    parameter int HW       = vga_pkg::cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = vga_pkg::cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    output logic              o_tick,
    output logic [HW-1:0]     o_hcount,
    output logic [VW-1:0]     o_vcount,
    output vga_pkg::vga_sig_t o_sig
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_S  = H_ACTIVE + H_FP;
    localparam int VS_S  = V_ACTIVE + V_FP;

    logic          r_tick;
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [31:0]   w_h;
    logic [31:0]   w_v;
    vga_sig_t      w_sig;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick   <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (i_enable) begin
            r_tick <= ~r_tick;
            if (r_tick) begin
                if (r_hcount == HW'(H_TOT - 1)) begin
                    r_hcount <= '0;
                    if (r_vcount == VW'(V_TOT - 1))
                        r_vcount <= '0;
                    else
                        r_vcount <= r_vcount + VW'(1);
                end else begin
                    r_hcount <= r_hcount + HW'(1);
                end
            end
        end
    end

    // Widen to 32 bits so the compares stay correct for any parameter set.
    assign w_h = 32'(r_hcount);
    assign w_v = 32'(r_vcount);

    assign w_sig.de     = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_sig.in_img = (w_h < IMG_W) && (w_v < IMG_H);
    assign w_sig.hs     = !((w_h >= HS_S) && (w_h < HS_S + H_SYNC));
    assign w_sig.vs     = !((w_v >= VS_S) && (w_v < VS_S + V_SYNC));

    assign o_tick   = r_tick;
    assign o_hcount = r_hcount;
    assign o_vcount = r_vcount;
    assign o_sig    = w_sig;
endmodule

// File: rtl/vga_frame_scanner.sv
// Scans the VGA raster, fetches framebuffer words and drives grey RGB plus syncs.
// Latency 2 pixel ticks (4 clk) counter-to-pins; no backpressure, enable low freezes all.
module vga_frame_scanner #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int IMG_W    = vga_pkg::IMG_W,
    parameter int IMG_H    = vga_pkg::IMG_H,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_pixel,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              pix_tick,
    output logic              frame_start
);
    import vga_pkg::*;

    localparam int HW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    // Syncs idle high so the first tick after reset never emits a false pulse.
    localparam vga_sig_t SIG_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, in_img: 1'b0};

    logic              w_tick;
    logic              w_step;
    logic [HW-1:0]     w_h;
    logic [VW-1:0]     w_v;
    vga_sig_t          w_sig;
    logic [ADDR_W-1:0] w_addr;
    logic              w_origin;
    logic              w_unused_hi;

    vga_sig_t          r_s1;
    logic              r_fs1;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_grey;
    logic              r_hs;
    logic              r_vs;
    logic              r_de;
    logic              r_fs;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .IMG_W    (IMG_W),    .IMG_H (IMG_H), .HW (HW),     .VW (VW)
    ) u_timing (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_enable (enable),
        .o_tick   (w_tick),
        .o_hcount (w_h),
        .o_vcount (w_v),
        .o_sig    (w_sig)
    );

    assign w_step      = enable & w_tick;
    assign w_addr      = w_sig.in_img ? (ADDR_W'(w_v) * IMG_W_A + ADDR_W'(w_h)) : '0;
    assign w_origin    = (w_h == '0) && (w_v == '0);
    assign w_unused_hi = ^mem_pixel[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= SIG_IDLE;
            r_fs1  <= 1'b0;
            r_addr <= '0;
            r_grey <= 8'h00;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_de   <= 1'b0;
            r_fs   <= 1'b0;
        end else if (w_step) begin
            r_s1   <= w_sig;
            r_fs1  <= w_origin;
            r_addr <= w_addr;
            r_grey <= (r_s1.de && r_s1.in_img) ? mem_pixel[7:0] : 8'h00;
            r_hs   <= r_s1.hs;
            r_vs   <= r_s1.vs;
            r_de   <= r_s1.de;
            r_fs   <= r_fs1;
        end
    end

    assign mem_addr    = r_addr;
    assign vga_r       = r_grey;
    assign vga_g       = r_grey;
    assign vga_b       = r_grey;
    assign vga_hsync   = r_hs;
    assign vga_vsync   = r_vs;
    assign vga_blank_n = r_de;
    assign pix_tick    = w_tick;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench on a shrunken raster (28x15 totals, 16x8 image) so whole frames stay short.
module tb_vga_frame_scanner;
    localparam int HT      = 28;
    localparam int VT      = 15;
    localparam int FRAME_E = 2 * HT * VT;

    typedef struct {
        int          h;
        int          v;
        bit          mode;
        logic [31:0] addr;
        logic [7:0]  grey;
        bit          hs;
        bit          vs;
        bit          de;
        bit          fs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_pixel = 32'h0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank_n, pix_tick, frame_start;

    bit mode = 1'b0;
    int checks = 0;
    int errors = 0;
    int edges = 0;
    vec_t tbl[16];

    vga_frame_scanner #(
        .H_ACTIVE (20), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .IMG_W    (16), .IMG_H (8), .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mem_addr    (mem_addr),
        .mem_pixel   (mem_pixel),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_blank_n (vga_blank_n),
        .pix_tick    (pix_tick),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous 1-cycle read port; upper bits carry junk the DUT must ignore.
    always @(posedge clk)
        mem_pixel <= mode ? 32'hFFFF_FFFF : {24'hA5A5A5, mem_addr[7:0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic adv_to(input int target);
        while (edges < target) clk1();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " r"}, 32'(vga_r), 32'h0);
        chk({tag, " g"}, 32'(vga_g), 32'h0);
        chk({tag, " b"}, 32'(vga_b), 32'h0);
        chk({tag, " hsync"}, 32'(vga_hsync), 32'h1);
        chk({tag, " vsync"}, 32'(vga_vsync), 32'h1);
        chk({tag, " blank_n"}, 32'(vga_blank_n), 32'h0);
        chk({tag, " addr"}, mem_addr, 32'h0);
        chk({tag, " fs"}, 32'(frame_start), 32'h0);
        chk({tag, " tick"}, 32'(pix_tick), 32'h0);
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int ta;
        ta = 2 * (t.v * HT + t.h) + 2;
        while (ta < edges) ta += FRAME_E;
        mode = t.mode;
        adv_to(ta);
        chk({tag, " addr"}, mem_addr, t.addr);
        adv_to(ta + 2);
        chk({tag, " r"}, 32'(vga_r), 32'(t.grey));
        chk({tag, " g"}, 32'(vga_g), 32'(t.grey));
        chk({tag, " b"}, 32'(vga_b), 32'(t.grey));
        chk({tag, " hsync"}, 32'(vga_hsync), 32'(t.hs));
        chk({tag, " vsync"}, 32'(vga_vsync), 32'(t.vs));
        chk({tag, " blank_n"}, 32'(vga_blank_n), 32'(t.de));
        chk({tag, " fs"}, 32'(frame_start), 32'(t.fs));
        chk({tag, " tick"}, 32'(pix_tick), 32'h0);
    endtask

    task automatic frame_stats();
        bit found;
        bit ph, pv, pf;
        int hs_f, hs_lo, vs_f, vs_lo, fs_r, rise_at, run, rmin, rmax;
        found = 1'b0;
        pf = frame_start;
        for (int i = 0; i < 2000 && !found; i++) begin
            clk1();
            if (frame_start && !pf) found = 1'b1;
            pf = frame_start;
        end
        chk("frame fs seen", 32'(found), 32'h1);
        hs_f = 0; hs_lo = 0; vs_f = 0; vs_lo = 0; fs_r = 0; rise_at = -1;
        run = 0; rmin = 100000; rmax = 0;
        ph = vga_hsync; pv = vga_vsync; pf = frame_start;
        for (int i = 1; i <= FRAME_E; i++) begin
            clk1();
            if (!vga_hsync) begin
                hs_lo++;
                run++;
                if (ph) hs_f++;
            end else if (!ph) begin
                if (run < rmin) rmin = run;
                if (run > rmax) rmax = run;
                run = 0;
            end
            if (!vga_vsync) begin
                vs_lo++;
                if (pv) vs_f++;
            end
            if (frame_start && !pf) begin
                fs_r++;
                rise_at = i;
            end
            ph = vga_hsync; pv = vga_vsync; pf = frame_start;
        end
        chk("frame hsync pulses", 32'(hs_f), 32'd15);
        chk("frame hsync low clk", 32'(hs_lo), 32'd90);
        chk("frame hsync min width", 32'(rmin), 32'd6);
        chk("frame hsync max width", 32'(rmax), 32'd6);
        chk("frame vsync pulses", 32'(vs_f), 32'd1);
        chk("frame vsync low clk", 32'(vs_lo), 32'd112);
        chk("frame fs pulses", 32'(fs_r), 32'd1);
        chk("frame period clk", 32'(rise_at), 32'(FRAME_E));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        h   v  mode addr    grey   hs vs de fs
        tbl[0]  = '{0,  0,  0, 32'd0,   8'h00, 1, 1, 1, 1};
        tbl[1]  = '{3,  2,  0, 32'd35,  8'h23, 1, 1, 1, 0};
        tbl[2]  = '{0,  7,  0, 32'd112, 8'h70, 1, 1, 1, 0};
        tbl[3]  = '{15, 7,  0, 32'd127, 8'h7F, 1, 1, 1, 0};
        tbl[4]  = '{16, 7,  1, 32'd0,   8'h00, 1, 1, 1, 0};
        tbl[5]  = '{19, 9,  1, 32'd0,   8'h00, 1, 1, 1, 0};
        tbl[6]  = '{20, 9,  1, 32'd0,   8'h00, 1, 1, 0, 0};
        tbl[7]  = '{22, 9,  1, 32'd0,   8'h00, 0, 1, 0, 0};
        tbl[8]  = '{24, 9,  1, 32'd0,   8'h00, 0, 1, 0, 0};
        tbl[9]  = '{25, 9,  1, 32'd0,   8'h00, 1, 1, 0, 0};
        tbl[10] = '{5,  10, 1, 32'd0,   8'h00, 1, 1, 0, 0};
        tbl[11] = '{5,  11, 1, 32'd0,   8'h00, 1, 0, 0, 0};
        tbl[12] = '{27, 12, 1, 32'd0,   8'h00, 1, 0, 0, 0};
        tbl[13] = '{0,  13, 1, 32'd0,   8'h00, 1, 1, 0, 0};
        tbl[14] = '{5,  3,  1, 32'd53,  8'hFF, 1, 1, 1, 0};
        tbl[15] = '{0,  0,  0, 32'd0,   8'h00, 1, 1, 1, 1};

        #12;
        chk_reset("reset");
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        clk1();
        chk("first edge tick", 32'(pix_tick), 32'h1);
        chk("first edge addr", mem_addr, 32'h0);

        for (int i = 0; i < 16; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        run_vec('{5, 4, 0, 32'd69, 8'h45, 1, 1, 1, 0}, "pre-freeze");
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 24) chk("freeze mid addr", mem_addr, 32'd70);
        end
        chk("freeze addr", mem_addr, 32'd70);
        chk("freeze r", 32'(vga_r), 32'h45);
        chk("freeze blank_n", 32'(vga_blank_n), 32'h1);
        chk("freeze tick", 32'(pix_tick), 32'h0);
        enable = 1'b1;
        run_vec('{6, 4, 0, 32'd70, 8'h46, 1, 1, 1, 0}, "resume0");
        run_vec('{7, 4, 0, 32'd71, 8'h47, 1, 1, 1, 0}, "resume1");

        frame_stats();

        run_vec('{10, 5, 0, 32'd90, 8'h5A, 1, 1, 1, 0}, "pre-areset");
        #2;
        reset = 1'b1;
        #1;
        chk_reset("areset");
        @(posedge clk);
        #1;
        chk("areset held addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        for (int k = 1; k <= 6; k++) begin
            clk1();
            chk($sformatf("restart fs e%0d", k), 32'(frame_start), ((k == 4) || (k == 5)) ? 32'h1 : 32'h0);
            if (k == 4) begin
                chk("restart blank_n", 32'(vga_blank_n), 32'h1);
                chk("restart addr", mem_addr, 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
